mux4to1_rr: RTL and testbench

- Four-to-one packet collector with round-robin arbitration. It merges four valid/ready input lanes onto one output stream and tags each output beat with its source lane index.
- Functionally the inverse of the team's 1-to-4 demultiplexer: lanes fanned out by sel are recombined here and carry their sel index back out.
- Sits between four lane producers and a single downstream consumer.
- Output is registered, so latency is 1 cycle and throughput is 1 beat per cycle.

---
 rtl/mux4to1_rr.sv | 116 +++++++++++
 tb/tb_mux4to1_rr.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux4to1_rr.sv
// Four-lane packet collector: round-robin grant per packet, lane locked until its last beat,
// single registered output stage tagged with the source lane index.
module mux4to1_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_last,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  typedef enum logic {ARB, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         ptr_reg, ptr_next;
  logic [1:0]         owner_reg, owner_next;
  logic               out_valid_reg, out_valid_next;
  logic [WIDTH-1:0]   out_data_reg, out_data_next;
  logic               out_last_reg, out_last_next;
  logic [1:0]         out_sel_reg, out_sel_next;

  logic [WIDTH-1:0]   lane_data [4];
  logic               load_en;
  logic               hit;
  logic [1:0]         grant;
  logic [1:0]         idx;
  logic               take;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = take && (grant == 2'(gi));
    end
  endgenerate

  assign load_en = !out_valid_reg || out_ready;
  assign take    = hit && load_en && !rst;

  // Descending scan so the last overwrite is the first valid lane at or after ptr.
  always_comb begin
    hit   = 1'b0;
    grant = 2'd0;
    idx   = 2'd0;
    if (state_reg == HOLD) begin
      hit   = in_valid[owner_reg];
      grant = owner_reg;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        idx = ptr_reg + 2'(k);
        if (in_valid[idx]) begin
          hit   = 1'b1;
          grant = idx;
        end
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    owner_next     = owner_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    out_sel_next   = out_sel_reg;
    if (take) begin
      out_valid_next = 1'b1;
      out_data_next  = lane_data[grant];
      out_last_next  = in_last[grant];
      out_sel_next   = grant;
      ptr_next       = grant + 2'd1;
      if (in_last[grant]) begin
        state_next = ARB;
      end else begin
        state_next = HOLD;
        owner_next = grant;
      end
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ARB;
      ptr_reg       <= 2'd0;
      owner_reg     <= 2'd0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_sel_reg   <= 2'd0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      owner_reg     <= owner_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      out_sel_reg   <= out_sel_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_mux4to1_rr.sv
// Directed bench for mux4to1_rr: single lane, round robin, packet lock, backpressure,
// owner bubble and reset mid-packet, each with hand-computed expectations.
module tb_mux4to1_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready;

  int total  = 0;
  int passed = 0;

  mux4to1_rr #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_lane(input int i, input logic v, input logic [7:0] d, input logic l);
    in_valid[i]      = v;
    in_data[i*8 +: 8] = d;
    in_last[i]       = l;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] s, input logic l);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
    chk({tag, ".last"},  32'(out_last),  32'(l));
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b1111; in_data = 32'h0; in_last = 4'b0; out_ready = 1'b1;
    tick(); tick();
    // reset state; lanes valid but ready must stay low under reset
    chk_out("reset", 1'b0, 8'h00, 2'd0, 1'b0);
    chk("reset.ready", 32'(in_ready), 32'h0);

    // single lane: lane 1 sends 0xA5 with last
    rst = 1'b0; in_valid = 4'b0;
    set_lane(1, 1'b1, 8'hA5, 1'b1);
    #1 chk("single.ready", 32'(in_ready), 32'b0010);
    tick();
    chk_out("single.out", 1'b1, 8'hA5, 2'd1, 1'b1);
    in_valid = 4'b0011;              // ptr is now 2: search 2,3,0 grants lane 0
    #1 chk("single.ptr2", 32'(in_ready), 32'b0001);
    in_valid = 4'b0;
    tick();
    chk("single.drain", 32'(out_valid), 32'h0);

    // round robin from reset: sel 0,1,2,3,0 with no bubbles
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 4'b1111; in_last = 4'b1111; in_data = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr.ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      tick();
      chk_out("rr.out", 1'b1, 8'(8'h10 + (k % 4)), 2'(k % 4), 1'b1);
    end
    in_valid = 4'b0;
    tick();
    chk("rr.drain", 32'(out_valid), 32'h0);

    // packet lock: ptr=1, lane 2 three beats while lane 0 stays valid
    in_last = 4'b0;
    set_lane(0, 1'b1, 8'h30, 1'b1);
    set_lane(2, 1'b1, 8'h21, 1'b0);
    #1 chk("lock.ready1", 32'(in_ready), 32'b0100);
    tick();
    chk_out("lock.b1", 1'b1, 8'h21, 2'd2, 1'b0);
    set_lane(2, 1'b1, 8'h22, 1'b0);
    #1 chk("lock.ready2", 32'(in_ready), 32'b0100);
    tick();
    chk_out("lock.b2", 1'b1, 8'h22, 2'd2, 1'b0);
    set_lane(2, 1'b1, 8'h23, 1'b1);
    #1 chk("lock.ready3", 32'(in_ready), 32'b0100);
    tick();
    chk_out("lock.b3", 1'b1, 8'h23, 2'd2, 1'b1);
    set_lane(2, 1'b0, 8'h00, 1'b0);
    #1 chk("lock.rel", 32'(in_ready), 32'b0001);
    tick();
    chk_out("lock.l0", 1'b1, 8'h30, 2'd0, 1'b1);
    in_valid = 4'b0;
    tick();

    // backpressure: ptr=1, lane 3 beats, out_ready low for 4 cycles
    set_lane(3, 1'b1, 8'h40, 1'b1);
    #1 chk("bp.ready", 32'(in_ready), 32'b1000);
    tick();
    chk_out("bp.first", 1'b1, 8'h40, 2'd3, 1'b1);
    out_ready = 1'b0;
    set_lane(3, 1'b1, 8'h41, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1 chk("bp.stall_rdy", 32'(in_ready), 32'h0);
      tick();
      chk_out("bp.hold", 1'b1, 8'h40, 2'd3, 1'b1);
    end
    out_ready = 1'b1;
    #1 chk("bp.release", 32'(in_ready), 32'b1000);
    tick();
    chk_out("bp.next", 1'b1, 8'h41, 2'd3, 1'b1);
    in_valid = 4'b0;
    tick();
    chk("bp.drain", 32'(out_valid), 32'h0);

    // owner bubble: ptr=0, lane 1 holds, drops valid 2 cycles, lane 3 waits
    set_lane(1, 1'b1, 8'h51, 1'b0);
    #1 chk("bub.ready", 32'(in_ready), 32'b0010);
    tick();
    chk_out("bub.b1", 1'b1, 8'h51, 2'd1, 1'b0);
    set_lane(1, 1'b0, 8'h00, 1'b0);
    set_lane(3, 1'b1, 8'h70, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1 chk("bub.blocked", 32'(in_ready), 32'h0);
      tick();
      chk("bub.idle", 32'(out_valid), 32'h0);
    end
    set_lane(1, 1'b1, 8'h52, 1'b1);
    #1 chk("bub.resume", 32'(in_ready), 32'b0010);
    tick();
    chk_out("bub.b2", 1'b1, 8'h52, 2'd1, 1'b1);
    set_lane(1, 1'b0, 8'h00, 1'b0);
    #1 chk("bub.l3rdy", 32'(in_ready), 32'b1000);
    tick();
    chk_out("bub.l3", 1'b1, 8'h70, 2'd3, 1'b1);
    in_valid = 4'b0;

    // reset mid-packet: ptr=0, lane 2 enters HOLD with beat buffered
    set_lane(2, 1'b1, 8'h81, 1'b0);
    #1 chk("rst.ready", 32'(in_ready), 32'b0100);
    tick();
    chk_out("rst.held", 1'b1, 8'h81, 2'd2, 1'b0);
    rst = 1'b1;
    in_valid = 4'b0;
    set_lane(0, 1'b1, 8'h90, 1'b1);
    set_lane(3, 1'b1, 8'h93, 1'b1);
    #1 chk("rst.rdy_in", 32'(in_ready), 32'h0);
    tick();
    chk("rst.valid", 32'(out_valid), 32'h0);
    chk("rst.rdy_hold", 32'(in_ready), 32'h0);
    rst = 1'b0;
    #1 chk("rst.l0rdy", 32'(in_ready), 32'b0001);
    tick();
    chk_out("rst.l0", 1'b1, 8'h90, 2'd0, 1'b1);
    #1 chk("rst.l3rdy", 32'(in_ready), 32'b1000);
    tick();
    chk_out("rst.l3", 1'b1, 8'h93, 2'd3, 1'b1);
    in_valid = 4'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
